// File: rtl/prime_pkg.sv
// Shared types for the sequential prime checker.
// Holds the controller state encoding and divider timing.
package prime_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        EVAL,
        DONE
    } state_t;

    localparam int WIDTH_DEF = 8;

    // The restoring divider retires one quotient bit per clock.
    localparam int DIV_CYCLES_PER_BIT = 1;

    // Number of clocks the controller dwells in DIV for a given width.
    function automatic int div_cycles(input int width);
        return width * DIV_CYCLES_PER_BIT;
    endfunction

endpackage

// File: rtl/mod_unit.sv
// Iterative restoring divider returning only the remainder.
// Fixed latency of div_cycles(WIDTH) clocks after load.
module mod_unit
    import prime_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem,
    output logic             rem_valid
);

    localparam int CYC = div_cycles(WIDTH);
    localparam int CW  = $clog2(CYC + 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] acc_nxt;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {acc, quo[WIDTH-1]};
        acc_nxt = shifted[WIDTH-1:0];
        if (shifted >= {1'b0, divisor}) begin
            acc_nxt = WIDTH'(shifted - {1'b0, divisor});
        end
    end

    // The final step's result is presented combinationally on its own cycle.
    assign rem       = acc_nxt;
    assign rem_valid = (cnt == CW'(1));

    // Partial remainder, dividend shifter and step counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            quo <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= '0;
            quo <= dividend;
            cnt <= CW'(CYC);
        end else if (cnt != '0) begin
            acc <= acc_nxt;
            quo <= {quo[WIDTH-2:0], 1'b0};
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/prime_seq_checker.sv
// Sequential primality checker using trial division.
// Tests d = 2, 3, ... while d*d <= n; one remainder per divider pass.
module prime_seq_checker
    import prime_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    output logic             busy,
    output logic             done,
    output logic             is_prime,
    output logic [WIDTH-1:0] n_out
);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]   n;
    logic [WIDTH-1:0]   d;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   div_rem;
    logic               div_valid;
    logic [2*WIDTH-1:0] d_sq;
    logic               accept;
    logic               launch;
    logic               set_prime;
    logic               d_step;

    // Square at double width so the bound test can never overflow.
    always_comb begin
        d_sq = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        launch    = 1'b0;
        set_prime = 1'b0;
        d_step    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (n < WIDTH'(2)) begin
                    state_nxt = DONE;
                end else if (d_sq > {{WIDTH{1'b0}}, n}) begin
                    set_prime = 1'b1;
                    state_nxt = DONE;
                end else begin
                    launch    = 1'b1;
                    state_nxt = DIV;
                end
            end
            DIV: begin
                if (div_valid) begin
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (rem_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    d_step    = 1'b1;
                    state_nxt = CHECK;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Controller state register; reset abandons any run in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand, divisor, captured remainder and verdict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n        <= '0;
            d        <= '0;
            rem_q    <= '0;
            is_prime <= 1'b0;
        end else begin
            if (accept) begin
                n        <= n_in;
                d        <= WIDTH'(2);
                rem_q    <= '0;
                is_prime <= 1'b0;
            end
            if (set_prime) begin
                is_prime <= 1'b1;
            end
            if (d_step) begin
                d <= d + WIDTH'(1);
            end
            if (state == DIV && div_valid) begin
                rem_q <= div_rem;
            end
        end
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign n_out = n;

    mod_unit #(
        .WIDTH(WIDTH)
    ) u_mod (
        .clk      (clk),
        .rst      (rst),
        .load     (launch),
        .dividend (n),
        .divisor  (d),
        .rem      (div_rem),
        .rem_valid(div_valid)
    );

endmodule

// File: tb/tb_prime_seq_checker.sv
// Scoreboard bench for prime_seq_checker at WIDTH=8 and WIDTH=4.
// Expected verdict and latency are queued at issue, checked on done.
module tb_prime_seq_checker;

    typedef struct {
        int n;
        int p;
        int lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start8 = 1'b0;
    logic [7:0] n_in8 = '0;
    logic       busy8, done8, prime8;
    logic [7:0] nout8;
    logic       start4 = 1'b0;
    logic [3:0] n_in4 = '0;
    logic       busy4, done4, prime4;
    logic [3:0] nout4;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8, e4;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat8 = 0, lat4 = 0;
    int   idle8 = 0, gap8 = 0;
    int   dcnt8 = 0, dcnt4 = 0;
    int   issued8 = 0, issued4 = 0;

    always #5 clk = ~clk;

    prime_seq_checker #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .n_in(n_in8),
        .busy(busy8), .done(done8), .is_prime(prime8), .n_out(nout8)
    );

    prime_seq_checker #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .n_in(n_in4),
        .busy(busy4), .done(done4), .is_prime(prime4), .n_out(nout4)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Naive reference: any divisor in 2..n-1 disqualifies.
    function automatic int prime_ref(input int n);
        if (n < 2) return 0;
        for (int k = 2; k < n; k++) begin
            if (n % k == 0) return 0;
        end
        return 1;
    endfunction

    // Cycles from accept edge to DONE, walking CHECK/DIV/EVAL timing.
    function automatic int model_lat(input int n, input int w);
        int c;
        c = 1;
        if (n < 2) return 2;
        for (int k = 2; k <= n; k++) begin
            if (k * k > n) return c + 1;
            c += w + 1;
            if (n % k == 0) return c + 1;
            c++;
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            lat8  = 0;
            idle8 = 0;
        end else begin
            if (busy8) begin
                if (idle8 > 0) gap8 = idle8;
                idle8 = 0;
                lat8++;
            end else begin
                idle8++;
            end
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("done8_unexpected", 1, 0);
                end else begin
                    e8 = q8.pop_front();
                    chk("n_out8", int'(nout8), e8.n);
                    chk("prime8", int'(prime8), e8.p);
                    chk("lat8", lat8, e8.lat);
                end
                dcnt8++;
                lat8 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            lat4 = 0;
        end else begin
            if (busy4) lat4++;
            if (done4) begin
                if (q4.size() == 0) begin
                    chk("done4_unexpected", 1, 0);
                end else begin
                    e4 = q4.pop_front();
                    chk("n_out4", int'(nout4), e4.n);
                    chk("prime4", int'(prime4), e4.p);
                    chk("lat4", lat4, e4.lat);
                end
                dcnt4++;
                lat4 = 0;
            end
        end
    end

    task automatic issue8(input int n);
        exp_t e;
        int   g;
        g = 0;
        while (busy8 && g < 3000) begin
            @(negedge clk); #1;
            g++;
        end
        if (busy8) chk("idle_wait8", int'(busy8), 0);
        e.n   = n;
        e.p   = prime_ref(n);
        e.lat = model_lat(n, 8);
        q8.push_back(e);
        issued8++;
        n_in8  = 8'(n);
        start8 = 1'b1;
        @(negedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic wait8();
        int g;
        g = 0;
        while (q8.size() != 0 && g < 3000) begin
            @(negedge clk); #1;
            g++;
        end
        if (q8.size() != 0) chk("timeout8", q8.size(), 0);
    endtask

    task automatic issue4(input int n);
        exp_t e;
        int   g;
        g = 0;
        while (busy4 && g < 3000) begin
            @(negedge clk); #1;
            g++;
        end
        if (busy4) chk("idle_wait4", int'(busy4), 0);
        e.n   = n;
        e.p   = prime_ref(n);
        e.lat = model_lat(n, 4);
        q4.push_back(e);
        issued4++;
        n_in4  = 4'(n);
        start4 = 1'b1;
        @(negedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic wait4();
        int g;
        g = 0;
        while (q4.size() != 0 && g < 3000) begin
            @(negedge clk); #1;
            g++;
        end
        if (q4.size() != 0) chk("timeout4", q4.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy8", int'(busy8), 0);
        chk("rst_done8", int'(done8), 0);
        chk("rst_prime8", int'(prime8), 0);
        chk("rst_nout8", int'(nout8), 0);
        chk("rst_busy4", int'(busy4), 0);
        rst = 1'b1;
        @(negedge clk); #1;

        for (int k = 0; k < 16; k++) begin
            issue4(k);
            wait4();
        end

        issue8(2);
        wait8();
        issue8(4);
        wait8();
        issue8(221);
        wait8();
        issue8(0);
        wait8();
        issue8(255);
        wait8();

        issue8(251);
        repeat (20) @(negedge clk);
        #1;
        n_in8  = 8'd9;
        start8 = 1'b1;
        @(negedge clk); #1;
        start8 = 1'b0;
        wait8();
        repeat (3) @(negedge clk);
        #1;
        chk("hold_prime8", int'(prime8), 1);
        chk("hold_nout8", int'(nout8), 251);
        chk("hold_done8", int'(done8), 0);

        issue8(121);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy8", int'(busy8), 0);
        chk("arst_done8", int'(done8), 0);
        chk("arst_prime8", int'(prime8), 0);
        chk("arst_nout8", int'(nout8), 0);
        q8.delete();
        issued8--;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (150) @(negedge clk);
        #1;
        issue8(121);
        wait8();

        issue8(7);
        wait8();
        gap8 = 0;
        issue8(8);
        chk("b2b_gap8", gap8, 1);
        wait8();

        repeat (5) @(negedge clk);
        chk("done_count8", dcnt8, issued8);
        chk("done_count4", dcnt4, issued4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
